// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU/UART sequencer and the ALU: state encodings,
// opcode constants, default widths and the opcode-valid check.
package alu_seq_pkg;

  localparam int unsigned NB_SEQ_DATA_DEF    = 8;
  localparam int unsigned NB_SEQ_OP_DEF      = 6;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;

  localparam logic [NB_SEQ_OP_DEF-1:0] ALU_OP_ADD = 6'h20;
  localparam logic [NB_SEQ_OP_DEF-1:0] ALU_OP_SUB = 6'h22;
  localparam logic [NB_SEQ_OP_DEF-1:0] ALU_OP_AND = 6'h24;
  localparam logic [NB_SEQ_OP_DEF-1:0] ALU_OP_OR  = 6'h25;
  localparam logic [NB_SEQ_OP_DEF-1:0] ALU_OP_XOR = 6'h26;
  localparam logic [NB_SEQ_OP_DEF-1:0] ALU_OP_NOR = 6'h27;
  localparam logic [NB_SEQ_OP_DEF-1:0] ALU_OP_SRA = 6'h03;
  localparam logic [NB_SEQ_OP_DEF-1:0] ALU_OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_SEND    = 3'd5
  } seq_state_e;

  function automatic logic op_valid(input logic [NB_SEQ_OP_DEF-1:0] op);
    case (op)
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR,
      ALU_OP_XOR, ALU_OP_NOR, ALU_OP_SRA, ALU_OP_SRL: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles, clears on i_clear, and
// flags expiry when the count reaches TIMEOUT_CYCLES-1 (self-clearing).
module alu_seq_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_expire = i_enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || o_expire) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Sequences the ALU from a UART byte stream (A, B, opcode) and returns the
// result over UART TX. Optional inter-byte timeout under ALU_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | await operand A
// WAIT_B  | await operand B
// WAIT_OP | await opcode
// EXEC    | ALU evaluates registered inputs, result latched at closing edge
// WAIT_TX | hold result until UART TX is free
// SEND    | one-cycle tx start pulse
module alu_uart_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NB_SEQ_DATA    = NB_SEQ_DATA_DEF,
  parameter int unsigned NB_SEQ_OP      = NB_SEQ_OP_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NB_SEQ_DATA-1:0] i_rx_data,
  input  logic                   i_rx_done,
  input  logic                   i_tx_busy,
  input  logic [NB_SEQ_DATA-1:0] i_alu_result,
  output logic [NB_SEQ_DATA-1:0] o_alu_data_A,
  output logic [NB_SEQ_DATA-1:0] o_alu_data_B,
  output logic [NB_SEQ_OP-1:0]   o_alu_op,
  output logic [NB_SEQ_DATA-1:0] o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_op_err,
  output logic                   o_timeout
);

  seq_state_e state_q, state_d;
  logic [NB_SEQ_DATA-1:0] data_a_q, data_b_q, tx_data_q;
  logic [NB_SEQ_OP-1:0]   alu_op_q;
  logic                   timeout_q, timeout_d;
  logic                   tmo_expire;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic tmo_en;
  assign tmo_en = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

  alu_seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clear  (i_rx_done || !tmo_en),
    .i_enable (tmo_en),
    .o_expire (tmo_expire)
  );
`else
  // No counter: partial transactions wait forever.
  assign tmo_expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // A received byte wins over a simultaneous timeout expiry.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE:    if (i_rx_done) state_d = ST_WAIT_B;
      ST_WAIT_B: begin
        if (i_rx_done) begin
          state_d = ST_WAIT_OP;
        end else if (tmo_expire) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          state_d = ST_EXEC;
        end else if (tmo_expire) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_EXEC:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (!i_tx_busy) state_d = ST_SEND;
      ST_SEND:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_a_q  <= '0;
      data_b_q  <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (i_rx_done && state_q == ST_IDLE)    data_a_q <= i_rx_data;
      if (i_rx_done && state_q == ST_WAIT_B)  data_b_q <= i_rx_data;
      if (i_rx_done && state_q == ST_WAIT_OP) alu_op_q <= i_rx_data[NB_SEQ_OP-1:0];
      if (state_q == ST_EXEC)                 tx_data_q <= i_alu_result;
    end
  end

  always_comb begin
    o_tx_start = (state_q == ST_SEND);
    o_busy     = (state_q == ST_EXEC) || (state_q == ST_WAIT_TX) || (state_q == ST_SEND);
    o_op_err   = (state_q == ST_EXEC) && !op_valid(alu_op_q);
    o_timeout  = timeout_q;
  end

  assign o_alu_data_A = data_a_q;
  assign o_alu_data_B = data_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_tx_data    = tx_data_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a behavioural ALU and a bench-driven
// UART TX busy line; timeout checks depend on ALU_SEQ_TIMEOUT_EN.
module tb_alu_uart_sequencer;
  import alu_seq_pkg::*;

  localparam int NBD = 8;
  localparam int NBO = 6;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NBD-1:0] rx_data = '0;
  logic           rx_done = 1'b0;
  logic           tx_busy = 1'b0;
  logic [NBD-1:0] alu_res;
  logic [NBD-1:0] alu_a, alu_b, tx_data;
  logic [NBO-1:0] alu_op;
  logic           tx_start, busy, op_err, timeout;

  always #5 clk = ~clk;

  alu_uart_sequencer #(
    .NB_SEQ_DATA(NBD), .NB_SEQ_OP(NBO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_busy(tx_busy), .i_alu_result(alu_res),
    .o_alu_data_A(alu_a), .o_alu_data_B(alu_b), .o_alu_op(alu_op),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
    .o_op_err(op_err), .o_timeout(timeout)
  );

  // Behavioural ALU: shifts move A by B.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_OP_ADD: alu_res = alu_a + alu_b;
      ALU_OP_SUB: alu_res = alu_a - alu_b;
      ALU_OP_AND: alu_res = alu_a & alu_b;
      ALU_OP_OR:  alu_res = alu_a | alu_b;
      ALU_OP_XOR: alu_res = alu_a ^ alu_b;
      ALU_OP_NOR: alu_res = ~(alu_a | alu_b);
      ALU_OP_SRA: alu_res = $signed(alu_a) >>> alu_b;
      ALU_OP_SRL: alu_res = alu_a >> alu_b;
      default:    alu_res = '0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;
  int tmo_pulses = 0;

  always @(negedge clk) if (timeout === 1'b1) tmo_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = '0;
  endtask

  // Sends the opcode and watches the EXEC/WAIT_TX/SEND window with TX idle.
  task automatic finish_op(input logic [7:0] op, input logic [7:0] exp, input logic err,
                           input logic [7:0] a, input logic [7:0] b, input string name);
    int first, nbusy, nstart, nerr;
    logic [7:0] sent;
    first = 0; nbusy = 0; nstart = 0; nerr = 0; sent = '0;
    send_byte(op);
    for (int k = 1; k <= 8; k++) begin
      if (busy) nbusy++;
      if (op_err) nerr++;
      if (tx_start) begin
        nstart++;
        if (first == 0) begin
          first = k;
          sent  = tx_data;
        end
      end
      @(negedge clk);
    end
    check({name, "/start_latency"}, first, 3);
    check({name, "/start_pulses"}, nstart, 1);
    check({name, "/busy_cycles"}, nbusy, 3);
    check({name, "/op_err_pulses"}, nerr, {31'd0, err});
    check({name, "/tx_data"}, sent, exp);
    check({name, "/hold_A"}, alu_a, a);
    check({name, "/hold_B"}, alu_b, b);
    check({name, "/hold_op"}, alu_op, op & 8'h3F);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp, input logic err, input string name);
    send_byte(a);
    send_byte(b);
    finish_op(op, exp, err, a, b, name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "/A"}, alu_a, 0);
    check({name, "/B"}, alu_b, 0);
    check({name, "/op"}, alu_op, 0);
    check({name, "/tx_data"}, tx_data, 0);
    check({name, "/flags"}, {tx_start, busy, op_err, timeout}, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int first, t0, bad;

    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 1'b0};
    vecs[2]  = '{8'hF0, 8'h02, 8'h03, 8'hFC, 1'b0};
    vecs[3]  = '{8'hF0, 8'h02, 8'h02, 8'h3C, 1'b0};
    vecs[4]  = '{8'h01, 8'h01, 8'h3F, 8'h00, 1'b1};
    vecs[5]  = '{8'h10, 8'h22, 8'hE0, 8'h32, 1'b0};
    vecs[6]  = '{8'hCC, 8'hAA, 8'h24, 8'h88, 1'b0};
    vecs[7]  = '{8'hCC, 8'hAA, 8'h25, 8'hEE, 1'b0};
    vecs[8]  = '{8'hCC, 8'hAA, 8'h26, 8'h66, 1'b0};
    vecs[9]  = '{8'hCC, 8'hAA, 8'h27, 8'h11, 1'b0};
    vecs[10] = '{8'hFF, 8'h02, 8'h20, 8'h01, 1'b0};
    vecs[11] = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0};

    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].err,
              $sformatf("vec%0d", i));
    end

    // TX busy for 10 cycles from EXEC, stray byte in the middle.
    tx_busy = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h20);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        rx_data = 8'hAA;
        rx_done = 1'b1;
      end else begin
        rx_done = 1'b0;
      end
      if (tx_start) bad++;
      if (!busy) bad++;
      @(negedge clk);
    end
    rx_done = 1'b0;
    tx_busy = 1'b0;
    check("txbusy/held", bad, 0);
    check("txbusy/no_early_start", tx_start, 0);
    @(negedge clk);
    check("txbusy/start", tx_start, 1);
    check("txbusy/data", tx_data, 8'h33);
    @(negedge clk);
    check("txbusy/start_done", {tx_start, busy}, 0);
    check("txbusy/AA_dropped_A", alu_a, 8'h11);
    run_txn(8'h02, 8'h03, 8'h20, 8'h05, 1'b0, "after_busy");

`ifdef ALU_SEQ_TIMEOUT_EN
    t0 = tmo_pulses;
    first = 0;
    send_byte(8'h05);
    for (int k = 1; k <= 40; k++) begin
      if (timeout && first == 0) first = k;
      @(negedge clk);
    end
    check("tmo/latency", first, 17);
    check("tmo/pulses", tmo_pulses - t0, 1);
    run_txn(8'h07, 8'h01, 8'h20, 8'h08, 1'b0, "tmo_recover");

    t0 = tmo_pulses;
    send_byte(8'h05);
    repeat (14) @(negedge clk);
    send_byte(8'h03);
    finish_op(8'h20, 8'h08, 1'b0, 8'h05, 8'h03, "tmo_edge");
    check("tmo_edge/no_timeout", tmo_pulses - t0, 0);
`else
    t0 = tmo_pulses;
    first = 0;
    send_byte(8'h05);
    repeat (40) @(negedge clk);
    send_byte(8'h03);
    finish_op(8'h20, 8'h08, 1'b0, 8'h05, 8'h03, "no_tmo");
    check("no_tmo/pulses", tmo_pulses - t0, first);
`endif

    // Reset while SEND is active: start must drop at once.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    repeat (2) @(negedge clk);
    check("rst_send/start_before", tx_start, 1);
    rst_n = 1'b0;
    #1;
    check("rst_send/start_async", {tx_start, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset with a partial transaction pending.
    send_byte(8'h05);
    send_byte(8'h03);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    run_txn(8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
